// File: rtl/layer_mac_sequencer.sv
// Time-multiplexed controller for one fully-connected layer: a single signed 8x8 MAC
// accumulates bias plus dot product per node, quantises it and hands it downstream.
module layer_mac_sequencer #(
    parameter int NIN     = 5,
    parameter int NODES   = 8,
    parameter int WADDR_W = 8,
    parameter int NODE_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [3:0]         x_sel,
    input  logic [7:0]         x_data,
    output logic [WADDR_W-1:0] w_addr,
    input  logic [7:0]         w_data,
    output logic [NODE_W-1:0]  b_addr,
    input  logic [15:0]        b_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NODE_W-1:0]  out_idx,
    output logic [7:0]         out_data
);
    typedef enum logic [2:0] {IDLE, ACC, QUANT, OUT, FIN} state_t;

    localparam logic [4:0]         LAST_K      = 5'(NIN);
    localparam logic [NODE_W-1:0]  LAST_NODE   = NODE_W'(NODES - 1);
    localparam logic [WADDR_W-1:0] NODE_STRIDE = WADDR_W'(NIN);

    state_t              state_q, state_d;
    logic [4:0]          k_q, k_d;
    logic [NODE_W-1:0]   node_q, node_d;
    logic [WADDR_W-1:0]  base_q, base_d;
    logic signed [22:0]  acc_q, acc_d;
    logic [7:0]          outData_q, outData_d;
    logic [NODE_W-1:0]   outIdx_q, outIdx_d;

    logic signed [15:0]  product;
    logic signed [22:0]  productExt;
    logic signed [22:0]  biasExt;
    logic [7:0]          qData;

    assign product    = 16'($signed(x_data)) * 16'($signed(w_data));
    assign productExt = {{7{product[15]}}, product};
    assign biasExt    = {{7{b_data[15]}}, b_data};

    // ReLU, then saturate; anything at or above 8160 would round to 128, so it clamps too.
    always_comb begin
        if (acc_q < 23'sd0) begin
            qData = 8'd0;
        end else if (acc_q >= 23'sd8160) begin
            qData = 8'd127;
        end else begin
            qData = 8'((acc_q + 23'sd32) >>> 6);
        end
    end

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        node_d    = node_q;
        base_d    = base_q;
        acc_d     = acc_q;
        outData_d = outData_q;
        outIdx_d  = outIdx_q;
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        x_sel     = 4'd0;
        w_addr    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACC;
                    k_d     = 5'd0;
                    node_d  = '0;
                    base_d  = '0;
                    acc_d   = '0;
                end
            end
            ACC: begin
                busy = 1'b1;
                if (k_q < LAST_K) begin
                    w_addr = base_q + WADDR_W'(k_q);
                end
                // Weight and bias ROMs answer one cycle late, so step k consumes element k-1.
                if (k_q != 5'd0) begin
                    x_sel = 4'(k_q - 5'd1);
                    acc_d = (k_q == 5'd1) ? (biasExt + productExt) : (acc_q + productExt);
                end
                if (k_q == LAST_K) begin
                    state_d = QUANT;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            QUANT: begin
                busy      = 1'b1;
                outData_d = qData;
                outIdx_d  = node_q;
                state_d   = OUT;
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    if (node_q == LAST_NODE) begin
                        state_d = FIN;
                    end else begin
                        state_d = ACC;
                        node_d  = node_q + NODE_W'(1);
                        base_d  = base_q + NODE_STRIDE;
                        k_d     = 5'd0;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            k_q       <= '0;
            node_q    <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            outData_q <= '0;
            outIdx_q  <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            node_q    <= node_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            outData_q <= outData_d;
            outIdx_q  <= outIdx_d;
        end
    end

    assign b_addr   = node_q;
    assign out_idx  = outIdx_q;
    assign out_data = outData_q;
endmodule
